mul_arbiter: RTL and testbench

//  Shares one 4x4 sequential shift-add multiplier between two requesters.

---
 rtl/mul_arbiter_if.sv | 39 +++
 rtl/mul_arbiter.sv | 104 ++++++++++
 tb/tb_mul_arbiter.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/mul_arbiter_if.sv
// Client and multiplier-side signals of the shared 4x4 multiplier arbiter.
// The arbiter uses the slave view; the client/multiplier environment the master view.
interface mul_arbiter_if #(
    parameter int W = 4
);
    logic           req0;
    logic [W-1:0]   a0;
    logic [W-1:0]   b0;
    logic           req1;
    logic [W-1:0]   a1;
    logic [W-1:0]   b1;
    logic           mul_ld;
    logic [W-1:0]   mul_a;
    logic [W-1:0]   mul_b;
    logic [2*W-1:0] mul_ry;
    logic           ack0;
    logic           ack1;
    logic [2*W-1:0] y;
    logic           busy;
    logic           gnt;

    modport slave (
        input  req0, a0, b0,
        input  req1, a1, b1,
        input  mul_ry,
        output mul_ld, mul_a, mul_b,
        output ack0, ack1, y,
        output busy, gnt
    );

    modport master (
        output req0, a0, b0,
        output req1, a1, b1,
        output mul_ry,
        input  mul_ld, mul_a, mul_b,
        input  ack0, ack1, y,
        input  busy, gnt
    );
endinterface

// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one sequential multiplier between two
// requesters: latch operands, pulse load, wait fixed run time, return product.
module mul_arbiter #(
    parameter int W          = 4,
    parameter int MUL_CYCLES = 4
) (
    input logic          clk,
    input logic          rst,
    mul_arbiter_if.slave bus
);
    localparam int CW =
        (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST =
        CW'(MUL_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_e;

    state_e           state_q, state_d;
    logic             last_q, last_d;
    logic             gnt_q, gnt_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [2*W-1:0]   y_q, y_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             winner;

    // Contention goes to whoever was not served last
    always_comb begin
        winner = bus.req1;
        if (bus.req0 && bus.req1) begin
            winner = ~last_q;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        a_d     = a_q;
        b_d     = b_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    state_d = LOAD;
                    gnt_d   = winner;
                    a_d     = winner ? bus.a1 : bus.a0;
                    b_d     = winner ? bus.b1 : bus.b0;
                end
            end
            LOAD: begin
                state_d = RUN;
                cnt_d   = '0;
            end
            RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    y_d     = bus.mul_ry;
                end
            end
            DONE: begin
                state_d = IDLE;
                last_d  = gnt_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            gnt_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.mul_ld = (state_q == LOAD);
    assign bus.mul_a  = a_q;
    assign bus.mul_b  = b_q;
    assign bus.y      = y_q;
    assign bus.gnt    = gnt_q;
    assign bus.busy   = (state_q != IDLE);
    assign bus.ack0   = (state_q == DONE) && !gnt_q;
    assign bus.ack1   = (state_q == DONE) && gnt_q;
endmodule

// File: tb/tb_mul_arbiter.sv
// Bench for mul_arbiter: cycle-level service model plus directed
// scenarios with hand-computed products and ack spacing.
module tb_mul_arbiter;
    localparam int W = 4;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mul_arbiter_if #(.W(W)) bus ();

    mul_arbiter #(
        .W(W),
        .MUL_CYCLES(N)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    int ld_cnt = 0;
    int ack1_cnt = 0;

    // Environment multiplier: product of the operands seen at the load pulse
    logic [7:0] prod = 8'd0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.mul_ld === 1'b1)
            prod <= 8'(bus.mul_a) * 8'(bus.mul_b);
    end
    assign bus.mul_ry = prod;

    // Service model: a grant occupies N+3 cycles counted from the grant edge
    bit         m_busy;
    int         m_t;
    bit         m_owner;
    bit         m_last;
    logic [3:0] m_a;
    logic [3:0] m_b;
    logic [7:0] m_y;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy  = 1'b0;
            m_t     = 0;
            m_owner = 1'b0;
            m_last  = 1'b1;
            m_a     = 4'd0;
            m_b     = 4'd0;
            m_y     = 8'd0;
        end else if (!m_busy) begin
            if (bus.req0 || bus.req1) begin
                if (bus.req0 && bus.req1) m_owner = !m_last;
                else m_owner = bus.req1;
                m_a    = m_owner ? bus.a1 : bus.a0;
                m_b    = m_owner ? bus.b1 : bus.b0;
                m_busy = 1'b1;
                m_t    = 0;
            end
        end else begin
            m_t = m_t + 1;
            if (m_t == N + 1) m_y = 8'(m_a) * 8'(m_b);
            if (m_t == N + 2) begin
                m_busy = 1'b0;
                m_last = m_owner;
            end
        end
    end

    task automatic check(input string nm,
                         input logic [15:0] act,
                         input logic [15:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h cycle %0d",
                      nm, act, exp, cyc);
    endtask

    always @(negedge clk) begin
        bit e_ack;
        e_ack = m_busy && (m_t == N + 1);
        check("busy",   16'(bus.busy),   16'(m_busy));
        check("mul_ld", 16'(bus.mul_ld), 16'(m_busy && m_t == 0));
        check("ack0",   16'(bus.ack0),   16'(e_ack && !m_owner));
        check("ack1",   16'(bus.ack1),   16'(e_ack && m_owner));
        check("gnt",    16'(bus.gnt),    16'(m_owner));
        check("mul_a",  16'(bus.mul_a),  16'(m_a));
        check("mul_b",  16'(bus.mul_b),  16'(m_b));
        check("y",      16'(bus.y),      16'(m_y));
        if (bus.mul_ld === 1'b1) ld_cnt++;
        if (bus.ack1 === 1'b1) ack1_cnt++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_ack(input bit id, input bit drop,
                            output int at);
        at = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if ((id ? bus.ack1 : bus.ack0) === 1'b1) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) check(id ? "ack1_timeout" : "ack0_timeout",
                          16'd0, 16'd1);
        if (drop) begin
            if (id) bus.req1 = 1'b0;
            else bus.req0 = 1'b0;
        end
    endtask

    initial begin
        int c0, t1, t2, t3, n0, n1;
        bus.req0 = 1'b0; bus.a0 = 4'd0; bus.b0 = 4'd0;
        bus.req1 = 1'b0; bus.a1 = 4'd0; bus.b1 = 4'd0;
        step(3);
        rst = 1'b1;
        step(2);

        // single req0: 9 x 11
        n0 = ld_cnt;
        bus.a0 = 4'd9; bus.b0 = 4'd11; bus.req0 = 1'b1;
        c0 = cyc;
        wait_ack(1'b0, 1'b1, t1);
        check("t2_y", 16'(bus.y), 16'd99);
        check("t2_latency", 16'(t1 - c0), 16'd6);
        check("t2_ld_pulses", 16'(ld_cnt - n0), 16'd1);
        check("t2_no_ack1", 16'(ack1_cnt), 16'd0);
        step(2);
        check("t2_idle", 16'(bus.busy), 16'd0);

        // req1 dropped during RUN: 7 x 6
        bus.a1 = 4'd7; bus.b1 = 4'd6; bus.req1 = 1'b1;
        step(3);
        bus.req1 = 1'b0;
        wait_ack(1'b1, 1'b0, t1);
        check("t5_y", 16'(bus.y), 16'd42);
        step(2);
        check("t5_idle", 16'(bus.busy), 16'd0);

        // both held: alternating service
        bus.a0 = 4'd3;  bus.b0 = 4'd5;
        bus.a1 = 4'd15; bus.b1 = 4'd15;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        wait_ack(1'b0, 1'b0, t1);
        check("t3_y0", 16'(bus.y), 16'd15);
        wait_ack(1'b1, 1'b0, t2);
        check("t3_y1", 16'(bus.y), 16'd225);
        check("t3_gap01", 16'(t2 - t1), 16'd7);
        wait_ack(1'b0, 1'b1, t3);
        bus.req1 = 1'b0;
        check("t3_y0b", 16'(bus.y), 16'd15);
        check("t3_gap10", 16'(t3 - t2), 16'd7);
        step(2);

        // operands changed after grant
        bus.a0 = 4'd9; bus.b0 = 4'd11; bus.req0 = 1'b1;
        step(3);
        bus.a0 = 4'd2; bus.b0 = 4'd3;
        wait_ack(1'b0, 1'b1, t1);
        check("t4_y", 16'(bus.y), 16'd99);
        step(2);

        // reset mid-RUN aborts; requester 0 wins afterwards
        bus.a1 = 4'd5; bus.b1 = 4'd5; bus.req1 = 1'b1;
        step(3);
        check("t1_busy_pre", 16'(bus.busy), 16'd1);
        rst = 1'b0;
        #1;
        check("t1_busy", 16'(bus.busy), 16'd0);
        check("t1_gnt", 16'(bus.gnt), 16'd0);
        check("t1_y", 16'(bus.y), 16'd0);
        check("t1_mul_a", 16'(bus.mul_a), 16'd0);
        bus.a0 = 4'd2; bus.b0 = 4'd7; bus.req0 = 1'b1;
        n1 = ack1_cnt;
        step(1);
        rst = 1'b1;
        wait_ack(1'b0, 1'b1, t1);
        check("t1_y0", 16'(bus.y), 16'd14);
        check("t1_no_ack1", 16'(ack1_cnt - n1), 16'd0);
        wait_ack(1'b1, 1'b1, t2);
        check("t1_y1", 16'(bus.y), 16'd25);
        step(2);

        // boundary operands, pending req waits
        bus.a0 = 4'd0; bus.b0 = 4'd0; bus.req0 = 1'b1;
        step(2);
        bus.a1 = 4'd15; bus.b1 = 4'd15; bus.req1 = 1'b1;
        n1 = ack1_cnt;
        check("t6_gnt", 16'(bus.gnt), 16'd0);
        wait_ack(1'b0, 1'b1, t1);
        check("t6_y0", 16'(bus.y), 16'd0);
        check("t6_wait", 16'(ack1_cnt - n1), 16'd0);
        wait_ack(1'b1, 1'b1, t2);
        check("t6_y1", 16'(bus.y), 16'd225);
        check("t6_gap", 16'(t2 - t1), 16'd7);
        step(3);
        check("ld_total", 16'(ld_cnt), 16'd11);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
